// File: rtl/trashbin_mem_pkg.sv
// Shared types and constants for the TrashbinCore memory-side bridge.
package trashbin_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_ACK
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_UNMAPPED
  } region_t;

  // MMIO register byte offsets within the 64 KiB window
  localparam logic [15:0] LED_OFS   = 16'h0000;
  localparam logic [15:0] CYCLE_OFS = 16'h0004;

  // Word offsets as seen by the register block
  localparam int unsigned MMIO_WOFS_W = 14;
  localparam logic [MMIO_WOFS_W-1:0] LED_WOFS   = LED_OFS[15:2];
  localparam logic [MMIO_WOFS_W-1:0] CYCLE_WOFS = CYCLE_OFS[15:2];

endpackage

// File: rtl/trashbin_mmio_regs.sv
// MMIO register block: LED register, free-running cycle counter, read mux.
module trashbin_mmio_regs
  import trashbin_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [MMIO_WOFS_W-1:0] wofs,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic [31:0]            leds
);

  logic [31:0] cycles;

  // LED register, only the LED offset is writable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= '0;
    end else if (wr && (wofs == LED_WOFS)) begin
      leds <= wdata;
    end
  end

  // Free-running cycle counter, wraps naturally, read-only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // Read mux, unknown offsets read as zero
  always_comb begin
    rdata = '0;
    if (wofs == LED_WOFS) begin
      rdata = leds;
    end else if (wofs == CYCLE_WOFS) begin
      rdata = cycles;
    end
  end

endmodule

// File: rtl/trashbin_mem_bridge.sv
// Memory-side responder for the TrashbinCore data interface: turns the core's
// stable-address/ReadOK read model and one-cycle store strobe into RAM and MMIO
// transactions, with a one-word read tag for zero-latency repeat reads.
module trashbin_mem_bridge
  import trashbin_mem_pkg::*;
#(
  parameter int unsigned RAM_AW         = 12,
  parameter int unsigned RAM_RD_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
  parameter logic [31:0] UNMAPPED_DATA  = 32'h0000_0000
)(
  input  logic              CoreClock,
  input  logic              CoreReset,
  input  logic [31:0]       AddressBus,
  input  logic [31:0]       DataWriteBus,
  input  logic              WriteAssert,
  output logic [31:0]       DataReadBus,
  output logic              ReadOK,
  output logic              WriteOK,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [31:0]       ram_rdata,
  output logic              ram_wr_en,
  output logic [31:0]       ram_wdata,
  output logic [31:0]       DebugLeds
);

  localparam logic [2:0] LAT = 3'(RAM_RD_LATENCY);

  state_t            state;
  logic [29:0]       tag;
  logic              tag_valid;
  logic [29:0]       rd_word;
  region_t           rd_rgn;
  logic [2:0]        lat_cnt;
  logic [RAM_AW-1:0] wr_word;
  logic              pend_valid;
  logic [29:0]       pend_word;
  logic [31:0]       pend_data;

  logic [29:0]       bus_word;
  region_t           bus_rgn;
  logic              tag_hit;
  logic              wr_go;
  logic [29:0]       wr_src_word;
  logic [31:0]       wr_src_data;
  region_t           wr_rgn;
  logic              mmio_wr;
  logic [MMIO_WOFS_W-1:0] mmio_wofs;
  logic [31:0]       mmio_rdata;
  logic [31:0]       rd_capture;
  logic              unused_bits;

  function automatic region_t decode(input logic [29:0] word);
    if ((word >> RAM_AW) == '0) begin
      return RGN_RAM;
    end else if (word[29:14] == MMIO_BASE[31:16]) begin
      return RGN_MMIO;
    end
    return RGN_UNMAPPED;
  endfunction

  assign bus_word    = AddressBus[31:2];
  assign unused_bits = ^AddressBus[1:0];
  assign bus_rgn     = decode(bus_word);
  assign tag_hit     = tag_valid && (tag == bus_word);

  // A deferred store takes precedence over a fresh strobe in IDLE
  assign wr_go       = (state == ST_IDLE) && (pend_valid || WriteAssert);
  assign wr_src_word = pend_valid ? pend_word : bus_word;
  assign wr_src_data = pend_valid ? pend_data : DataWriteBus;
  assign wr_rgn      = decode(wr_src_word);
  assign mmio_wr     = wr_go && (wr_rgn == RGN_MMIO);
  assign mmio_wofs   = (state == ST_RD_WAIT) ? rd_word[MMIO_WOFS_W-1:0]
                                             : wr_src_word[MMIO_WOFS_W-1:0];

  // A pending store may target the tagged word, so its data is not yet trustworthy
  assign ReadOK = (state == ST_IDLE) && tag_hit && !WriteAssert && !pend_valid;

  // RAM address follows the bus in IDLE and holds the in-flight word otherwise
  always_comb begin
    ram_addr = bus_word[RAM_AW-1:0];
    case (state)
      ST_RD_WAIT: ram_addr = rd_word[RAM_AW-1:0];
      ST_WR_ACK:  ram_addr = wr_word;
      default:    ram_addr = bus_word[RAM_AW-1:0];
    endcase
  end

  // Read-data source selected by the region sampled at issue
  always_comb begin
    rd_capture = UNMAPPED_DATA;
    case (rd_rgn)
      RGN_RAM:  rd_capture = ram_rdata;
      RGN_MMIO: rd_capture = mmio_rdata;
      default:  rd_capture = UNMAPPED_DATA;
    endcase
  end

  trashbin_mmio_regs u_mmio (
    .clk   (CoreClock),
    .rst   (CoreReset),
    .wr    (mmio_wr),
    .wofs  (mmio_wofs),
    .wdata (wr_src_data),
    .rdata (mmio_rdata),
    .leds  (DebugLeds)
  );

  // Transaction FSM with registered strobes, read tag and pending-store slot
  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      state       <= ST_IDLE;
      tag         <= '0;
      tag_valid   <= 1'b0;
      rd_word     <= '0;
      rd_rgn      <= RGN_UNMAPPED;
      lat_cnt     <= '0;
      DataReadBus <= '0;
      WriteOK     <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wdata   <= '0;
      wr_word     <= '0;
      pend_valid  <= 1'b0;
      pend_word   <= '0;
      pend_data   <= '0;
    end else begin
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
      WriteOK   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_go) begin
            ram_wr_en <= (wr_rgn == RGN_RAM);
            ram_wdata <= wr_src_data;
            wr_word   <= wr_src_word[RAM_AW-1:0];
            if (tag == wr_src_word) begin
              tag_valid <= 1'b0;
            end
            WriteOK <= 1'b1;
            state   <= ST_WR_ACK;
            if (pend_valid && WriteAssert) begin
              pend_word <= bus_word;
              pend_data <= DataWriteBus;
            end else begin
              pend_valid <= 1'b0;
            end
          end else if (!tag_hit) begin
            rd_word <= bus_word;
            rd_rgn  <= bus_rgn;
            if (bus_rgn == RGN_RAM) begin
              ram_rd_en <= 1'b1;
              lat_cnt   <= LAT;
            end else begin
              lat_cnt <= 3'd1;
            end
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (WriteAssert) begin
            pend_valid <= 1'b1;
            pend_word  <= bus_word;
            pend_data  <= DataWriteBus;
          end
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
            DataReadBus <= rd_capture;
            tag         <= rd_word;
            tag_valid   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          if (WriteAssert) begin
            pend_valid <= 1'b1;
            pend_word  <= bus_word;
            pend_data  <= DataWriteBus;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trashbin_mem_bridge.sv
// Bench for trashbin_mem_bridge: two instances (RAM latency 1 and 3) sharing
// the core-side stimulus, each with its own behavioural RAM.
module tb_trashbin_mem_bridge;

  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        wa   = 1'b0;

  logic [31:0] rdata1, leds1, ram_rdata1, ram_wdata1;
  logic        rdok1, wrok1, rden1, wren1;
  logic [AW-1:0] raddr1;
  logic [31:0] rdata3, leds3, ram_rdata3, ram_wdata3;
  logic        rdok3, wrok3, rden3, wren3;
  logic [AW-1:0] raddr3;

  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] p3a, p3b;
  logic init1 = 1'b0;
  logic init3 = 1'b0;
  int rd_cnt1 = 0, wr_cnt1 = 0, rd_cnt3 = 0, wr_cnt3 = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trashbin_mem_bridge #(
    .RAM_AW(AW), .RAM_RD_LATENCY(1),
    .MMIO_BASE(32'hFFFF_0000), .UNMAPPED_DATA(32'hDEAD_0BAD)
  ) u_dut1 (
    .CoreClock(clk), .CoreReset(rst), .AddressBus(addr), .DataWriteBus(wdat),
    .WriteAssert(wa), .DataReadBus(rdata1), .ReadOK(rdok1), .WriteOK(wrok1),
    .ram_addr(raddr1), .ram_rd_en(rden1), .ram_rdata(ram_rdata1),
    .ram_wr_en(wren1), .ram_wdata(ram_wdata1), .DebugLeds(leds1)
  );

  trashbin_mem_bridge #(
    .RAM_AW(AW), .RAM_RD_LATENCY(3),
    .MMIO_BASE(32'hFFFF_0000), .UNMAPPED_DATA(32'h0000_0000)
  ) u_dut3 (
    .CoreClock(clk), .CoreReset(rst), .AddressBus(addr), .DataWriteBus(wdat),
    .WriteAssert(wa), .DataReadBus(rdata3), .ReadOK(rdok3), .WriteOK(wrok3),
    .ram_addr(raddr3), .ram_rd_en(rden3), .ram_rdata(ram_rdata3),
    .ram_wr_en(wren3), .ram_wdata(ram_wdata3), .DebugLeds(leds3)
  );

  function automatic logic [31:0] f(input int i);
    return 32'h0000_0013 + (32'(i) << 8);
  endfunction

  // Latency-1 RAM; data is garbage unless read exactly one cycle earlier
  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < 64; i++) mem1[i] <= f(i);
      init1 <= 1'b1;
    end else begin
      if (wren1) mem1[raddr1] <= ram_wdata1;
      ram_rdata1 <= rden1 ? mem1[raddr1] : 32'hBADB_AD00;
    end
    if (rden1) rd_cnt1 <= rd_cnt1 + 1;
    if (wren1) wr_cnt1 <= wr_cnt1 + 1;
  end

  // Latency-3 RAM
  always @(posedge clk) begin
    if (!init3) begin
      for (int i = 0; i < 64; i++) mem3[i] <= f(i);
      init3 <= 1'b1;
    end else begin
      if (wren3) mem3[raddr3] <= ram_wdata3;
      p3a <= rden3 ? mem3[raddr3] : 32'hBADB_AD00;
    end
    p3b        <= p3a;
    ram_rdata3 <= p3b;
    if (rden3) rd_cnt3 <= rd_cnt3 + 1;
    if (wren3) wr_cnt3 <= wr_cnt3 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wa = 1'b0; wdat = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Read through instance 1; n = samples until ReadOK (-1 on timeout)
  task automatic rd1(input logic [31:0] a, input bit rel, output logic [31:0] d, output int n);
    @(negedge clk);
    addr = a; wa = 1'b0;
    if (rel) rst = 1'b0;
    #1;
    n = -1; d = '0;
    for (int k = 0; k < 20; k++) begin
      if (rdok1) begin
        n = k; d = rdata1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wa = 1'b1; wdat = d;
    @(negedge clk);
    wa = 1'b0; #1;
    chk("wr1 WriteOK", 32'(wrok1), 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic        rdok, wrok, rden, wren;
    logic [31:0] data;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic rdok, input logic wrok, input logic rden,
                              input logic wren, input logic [31:0] data);
    vec_t v;
    v.a = a; v.w = w; v.d = d; v.rdok = rdok; v.wrok = wrok;
    v.rden = rden; v.wren = wren; v.data = data;
    return v;
  endfunction

  initial begin
    vec_t tbl [17];
    logic [31:0] d, v1, v2, v3;
    int n, first, base_rd, base_wr;

    // Fetch miss, hold, store/reload, store to the tagged word (latency-1 instance)
    tbl[0]  = mk(32'h00, 0, 0,             0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h00, 0, 0,             0, 0, 1, 0, 0);
    tbl[2]  = mk(32'h00, 0, 0,             0, 0, 0, 0, 0);
    tbl[3]  = mk(32'h00, 0, 0,             1, 0, 0, 0, 32'h13);
    tbl[4]  = mk(32'h00, 0, 0,             1, 0, 0, 0, 32'h13);
    tbl[5]  = mk(32'h40, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    tbl[6]  = mk(32'h40, 0, 0,             0, 1, 0, 1, 0);
    tbl[7]  = mk(32'h40, 0, 0,             0, 0, 0, 0, 0);
    tbl[8]  = mk(32'h40, 0, 0,             0, 0, 1, 0, 0);
    tbl[9]  = mk(32'h40, 0, 0,             0, 0, 0, 0, 0);
    tbl[10] = mk(32'h40, 0, 0,             1, 0, 0, 0, 32'hCAFE_F00D);
    tbl[11] = mk(32'h40, 1, 32'h1234_5678, 0, 0, 0, 0, 0);
    tbl[12] = mk(32'h40, 0, 0,             0, 1, 0, 1, 0);
    tbl[13] = mk(32'h40, 0, 0,             0, 0, 0, 0, 0);
    tbl[14] = mk(32'h40, 0, 0,             0, 0, 1, 0, 0);
    tbl[15] = mk(32'h40, 0, 0,             0, 0, 0, 0, 0);
    tbl[16] = mk(32'h40, 0, 0,             1, 0, 0, 0, 32'h1234_5678);

    // Reset values
    @(negedge clk); @(negedge clk); #1;
    chk("rst ReadOK", 32'(rdok1), 32'd0);
    chk("rst WriteOK", 32'(wrok1), 32'd0);
    chk("rst DataReadBus", rdata1, 32'd0);
    chk("rst DebugLeds", leds1, 32'd0);
    chk("rst ram_rd_en", 32'(rden1), 32'd0);
    chk("rst ram_wr_en", 32'(wren1), 32'd0);
    chk("rst ReadOK lat3", 32'(rdok3), 32'd0);

    base_rd = rd_cnt1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      addr = tbl[i].a; wa = tbl[i].w; wdat = tbl[i].d;
      #1;
      chk($sformatf("row%0d ReadOK", i), 32'(rdok1), 32'(tbl[i].rdok));
      chk($sformatf("row%0d WriteOK", i), 32'(wrok1), 32'(tbl[i].wrok));
      chk($sformatf("row%0d ram_rd_en", i), 32'(rden1), 32'(tbl[i].rden));
      chk($sformatf("row%0d ram_wr_en", i), 32'(wren1), 32'(tbl[i].wren));
      if (tbl[i].rdok) chk($sformatf("row%0d DataReadBus", i), rdata1, tbl[i].data);
    end
    chk("table read strobes", 32'(rd_cnt1 - base_rd), 32'd3);

    // Address change mid-read on the latency-3 instance
    do_reset();
    base_rd = rd_cnt3;
    @(negedge clk); rst = 1'b0; addr = 32'h10; wa = 1'b0; #1;
    @(negedge clk); #1;
    chk("chg ram_rd_en", 32'(rden3), 32'd1);
    @(negedge clk); addr = 32'h20; #1;
    chk("chg ram_addr held", 32'(raddr3), 32'd4);
    chk("chg ReadOK early", 32'(rdok3), 32'd0);
    first = -1;
    for (int s = 3; s < 15; s++) begin
      @(negedge clk); #1;
      if (rdok3) begin
        if (first < 0) first = s;
        chk($sformatf("chg data s%0d", s), rdata3, f(8));
      end
    end
    chk("chg first ReadOK", 32'(first), 32'd10);
    chk("chg read strobes", 32'(rd_cnt3 - base_rd), 32'd2);

    // Store during RD_WAIT is deferred until the read completes
    base_wr = wr_cnt3;
    @(negedge clk); addr = 32'h30; #1;
    chk("defer ReadOK miss", 32'(rdok3), 32'd0);
    @(negedge clk); addr = 32'h44; wa = 1'b1; wdat = 32'hDEAD_BEEF; #1;
    chk("defer WriteOK t1", 32'(wrok3), 32'd0);
    for (int t = 2; t < 6; t++) begin
      @(negedge clk); wa = 1'b0; #1;
      chk($sformatf("defer WriteOK t%0d", t), 32'(wrok3), 32'd0);
    end
    chk("defer old read done", rdata3, f(12));
    @(negedge clk); #1;
    chk("defer WriteOK t6", 32'(wrok3), 32'd1);
    chk("defer ram_wr_en t6", 32'(wren3), 32'd1);
    chk("defer ram_addr t6", 32'(raddr3), 32'd17);
    @(negedge clk); #1;
    chk("defer WriteOK t7", 32'(wrok3), 32'd0);
    first = -1;
    for (int t = 7; t < 20; t++) begin
      if (rdok3) begin
        first = t;
        break;
      end
      @(negedge clk); #1;
    end
    chk("defer reread cycle", 32'(first), 32'd12);
    chk("defer reread data", rdata3, 32'hDEAD_BEEF);
    chk("defer single wr_en", 32'(wr_cnt3 - base_wr), 32'd1);
    chk("defer ram content", mem3[17], 32'hDEAD_BEEF);

    // MMIO on the latency-1 instance
    do_reset();
    base_wr = wr_cnt1;
    @(negedge clk); rst = 1'b0; addr = 32'hFFFF_0000; wa = 1'b1; wdat = 32'h5; #1;
    chk("led ReadOK", 32'(rdok1), 32'd0);
    @(negedge clk); wa = 1'b0; #1;
    chk("led WriteOK", 32'(wrok1), 32'd1);
    chk("led DebugLeds", leds1, 32'd5);
    chk("led no ram_wr_en", 32'(wren1), 32'd0);
    rd1(32'hFFFF_0004, 1'b0, v1, n);
    chk("cyc1 latency", 32'(n), 32'd3);
    chk("cyc1 value", v1, 32'd4);
    rd1(32'hFFFF_0000, 1'b0, d, n);
    chk("led readback", d, 32'd5);
    rd1(32'hFFFF_0004, 1'b0, v2, n);
    chk("cyc2 value", v2, 32'd12);
    chk("cyc increasing", 32'(v2 > v1), 32'd1);
    wr1(32'hFFFF_0004, 32'h0);
    chk("cyc write leds kept", leds1, 32'd5);
    rd1(32'hFFFF_0004, 1'b0, v3, n);
    chk("cyc3 latency", 32'(n), 32'd3);
    chk("cyc3 value", v3, 32'd18);
    rd1(32'h8000_0000, 1'b0, d, n);
    chk("unmapped latency", 32'(n), 32'd3);
    chk("unmapped data", d, 32'hDEAD_0BAD);
    rd1(32'h0000_0100, 1'b0, d, n);
    chk("ram end+1 unmapped", d, 32'hDEAD_0BAD);
    rd1(32'h0000_00FC, 1'b0, d, n);
    chk("ram last word", d, f(63));
    rd1(32'hFFFF_0008, 1'b0, d, n);
    chk("mmio other zero", d, 32'd0);
    rd1(32'hFFFE_FFFC, 1'b0, d, n);
    chk("below mmio unmapped", d, 32'hDEAD_0BAD);
    chk("mmio no ram writes", 32'(wr_cnt1 - base_wr), 32'd0);

    // Reset while a read is outstanding
    @(negedge clk); addr = 32'h10; #1;
    @(negedge clk); #1;
    chk("rstrd ram_rd_en", 32'(rden1), 32'd1);
    rst = 1'b1; #1;
    base_rd = rd_cnt1;
    chk("rstrd ReadOK", 32'(rdok1), 32'd0);
    chk("rstrd WriteOK", 32'(wrok1), 32'd0);
    chk("rstrd DebugLeds", leds1, 32'd0);
    chk("rstrd ram_rd_en off", 32'(rden1), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    chk("rstrd no strobes", 32'(rd_cnt1 - base_rd), 32'd0);
    rd1(32'hFFFF_0004, 1'b1, d, n);
    chk("rstrd restart latency", 32'(n), 32'd3);
    chk("rstrd counter cleared", d, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
